// File: rtl/k_calculation_seq.sv
// k_calculation_seq: sequential Golomb parameter search.
// Finds the smallest k in 0..K_MAX with (N << k) >= A_eff, testing STEPS
// candidate values per cycle, with a valid/ready handshake on both sides.
module k_calculation_seq #(
    parameter int N_length    = 7,
    parameter int A_length    = 13,
    parameter int mode_length = 2,
    parameter int k_length    = 4,
    parameter int K_MAX       = 14,
    parameter int STEPS       = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_length-1:0]    N,
    input  logic [A_length-1:0]    A,
    input  logic [mode_length-1:0] mode,
    input  logic                   RIType,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [k_length-1:0]    k,
    output logic                   k_sat
);

    localparam int AE_W    = A_length + 1;
    localparam int SHIFT_W = N_length + K_MAX;
    localparam int CMP_W   = (SHIFT_W > AE_W) ? SHIFT_W : AE_W;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [N_length-1:0] n_reg;
    logic [AE_W-1:0]     a_eff_reg;
    logic [AE_W-1:0]     a_eff_in;
    logic [k_length-1:0] k_reg;
    logic [k_length-1:0] k_next;
    logic                k_sat_reg;
    logic                k_sat_next;

    logic                hit;
    logic [k_length-1:0] hit_k;
    logic                hit_sat;
    int                  cand;
    logic [CMP_W-1:0]    shifted;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign k         = k_reg;
    assign k_sat     = k_sat_reg;

    // Effective error target captured on accept; unsupported modes get a zero
    // target so the first compare cycle terminates at k=0 without saturation.
    always_comb begin
        a_eff_in = '0;
        if (mode == mode_length'(0)) begin
            a_eff_in = AE_W'(A);
        end else if (mode == mode_length'(2)) begin
            a_eff_in = AE_W'(A) + (RIType ? AE_W'(N >> 1) : AE_W'(0));
        end
    end

    // Up to STEPS chained tests starting at the current k; the first
    // terminating candidate wins, later candidates are ignored.
    always_comb begin
        hit     = 1'b0;
        hit_k   = k_reg;
        hit_sat = 1'b0;
        cand    = 0;
        shifted = '0;
        for (int s = 0; s < STEPS; s++) begin
            cand    = int'(k_reg) + s;
            shifted = CMP_W'(n_reg) << cand;
            if (!hit && ((cand == K_MAX) || (shifted >= CMP_W'(a_eff_reg)))) begin
                hit     = 1'b1;
                hit_k   = k_length'(cand);
                hit_sat = (cand == K_MAX) && (shifted < CMP_W'(a_eff_reg));
            end
        end
    end

    // Next-state and result update for the IDLE/CALC/DONE handshake FSM.
    always_comb begin
        state_next = state;
        k_next     = k_reg;
        k_sat_next = k_sat_reg;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = CALC;
                    k_next     = '0;
                    k_sat_next = 1'b0;
                end
            end
            CALC: begin
                if (hit) begin
                    state_next = DONE;
                    k_next     = hit_k;
                    k_sat_next = hit_sat;
                end else begin
                    k_next = k_reg + k_length'(STEPS);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and result registers; reset aborts any search in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            k_reg     <= '0;
            k_sat_reg <= 1'b0;
        end else begin
            state     <= state_next;
            k_reg     <= k_next;
            k_sat_reg <= k_sat_next;
        end
    end

    // Operand capture, only on an accepted request so later input changes
    // have no effect on the running search.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_reg     <= '0;
            a_eff_reg <= '0;
        end else if (in_valid && (state == IDLE)) begin
            n_reg     <= N;
            a_eff_reg <= a_eff_in;
        end
    end

endmodule

// File: tb/tb_k_calculation_seq.sv
// tb_k_calculation_seq: directed scoreboard bench for k_calculation_seq,
// running a STEPS=1 and a STEPS=4 instance on shared inputs.
module tb_k_calculation_seq;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [6:0] N;
    logic [12:0] A;
    logic [1:0] mode;
    logic       RIType;
    logic       out_ready;

    logic       in_ready;
    logic       out_valid;
    logic [3:0] k;
    logic       k_sat;
    logic       in_ready4;
    logic       out_valid4;
    logic [3:0] k4;
    logic       k_sat4;

    typedef struct {
        int k;
        int sat;
        int lat1;
        int lat4;
    } exp_t;

    exp_t sb[$];
    int   compared;
    int   mismatched;

    k_calculation_seq #(.STEPS(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .N(N), .A(A), .mode(mode), .RIType(RIType),
        .out_valid(out_valid), .out_ready(out_ready), .k(k), .k_sat(k_sat)
    );

    k_calculation_seq #(.STEPS(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
        .N(N), .A(A), .mode(mode), .RIType(RIType),
        .out_valid(out_valid4), .out_ready(out_ready), .k(k4), .k_sat(k_sat4)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference result: smallest k with (N<<k) >= A_eff, else 14 saturated.
    function automatic exp_t model(input int n, input int a, input int md, input int ri);
        exp_t e;
        longint ae;
        bit found;
        e.k = 0; e.sat = 0; e.lat1 = 1; e.lat4 = 1;
        if (md != 0 && md != 2) return e;
        ae = (md == 2 && ri != 0) ? longint'(a) + longint'(n / 2) : longint'(a);
        found = 0;
        for (int j = 0; j <= 14; j++) begin
            if (!found && ((longint'(n) << j) >= ae)) begin
                found = 1;
                e.k = j;
            end
        end
        if (!found) begin
            e.k = 14;
            e.sat = 1;
        end
        e.lat1 = e.k + 1;
        e.lat4 = e.k / 4 + 1;
        return e;
    endfunction

    task automatic run_req(input string tag, input int n_in, input int a_in,
                           input int mode_in, input int ri_in, input int hold);
        exp_t e;
        int cnt;
        int lat1;
        int lat4;
        sb.push_back(model(n_in, a_in, mode_in, ri_in));
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        N = 7'(n_in); A = 13'(a_in); mode = 2'(mode_in); RIType = 1'(ri_in);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        N = 7'($urandom); A = 13'($urandom); mode = 2'($urandom_range(3)); RIType = 1'($urandom_range(1));
        cnt = 0; lat1 = -1; lat4 = -1;
        if (out_valid) lat1 = 0;
        if (out_valid4) lat4 = 0;
        while ((lat1 < 0 || lat4 < 0) && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
            if (out_valid && lat1 < 0) lat1 = cnt;
            if (out_valid4 && lat4 < 0) lat4 = cnt;
        end
        e = sb.pop_front();
        check({tag, "_lat"}, 32'(lat1), 32'(e.lat1));
        check({tag, "_lat4"}, 32'(lat4), 32'(e.lat4));
        check({tag, "_k"}, {28'd0, k}, 32'(e.k));
        check({tag, "_ksat"}, {31'd0, k_sat}, 32'(e.sat));
        check({tag, "_k4"}, {28'd0, k4}, 32'(e.k));
        check({tag, "_ksat4"}, {31'd0, k_sat4}, 32'(e.sat));
        repeat (hold) begin
            @(posedge clk); #1;
            check({tag, "_hold_k"}, {28'd0, k}, 32'(e.k));
            check({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
            check({tag, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check({tag, "_release_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_release_in_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_release_in_ready4"}, {31'd0, in_ready4}, 32'd1);
    endtask

    // Directed sequence: reset, spec cases, boundaries, abort, random sweep.
    initial begin
        int seen;
        int md;
        compared = 0; mismatched = 0;
        clk = 1'b0; reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        N = '0; A = '0; mode = '0; RIType = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_k", {28'd0, k}, 32'd0);
        check("rst_ksat", {31'd0, k_sat}, 32'd0);

        run_req("n4_a20", 4, 20, 0, 0, 0);
        run_req("ri1", 6, 10, 2, 1, 0);
        run_req("ri0", 6, 10, 2, 0, 0);
        run_req("n0_sat", 0, 5, 0, 0, 0);
        run_req("bypass", 9, 100, 1, 1, 0);
        run_req("bypass3", 0, 8191, 3, 0, 0);
        run_req("a_zero", 5, 0, 0, 0, 0);
        run_req("n0_a0", 0, 0, 0, 0, 0);
        run_req("n1_amax", 1, 8191, 0, 0, 0);
        run_req("aeff_wide", 127, 8191, 2, 1, 0);
        run_req("backpressure", 4, 20, 0, 0, 3);

        // Abort a long search with an asynchronous reset pulse.
        N = 7'd1; A = 13'd8191; mode = 2'd0; RIType = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_busy", {31'd0, in_ready}, 32'd0);
        reset = 1'b1;
        #1;
        check("abort_k", {28'd0, k}, 32'd0);
        check("abort_ksat", {31'd0, k_sat}, 32'd0);
        check("abort_valid", {31'd0, out_valid}, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        check("abort_in_ready4", {31'd0, in_ready4}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid || out_valid4) seen = 1;
        end
        check("abort_no_pulse", 32'(seen), 32'd0);
        run_req("after_abort", 4, 20, 0, 0, 0);

        for (int i = 0; i < 8; i++) begin
            md = (i % 4 == 3) ? 1 : ((i % 2) * 2);
            run_req($sformatf("rand%0d", i), int'($urandom_range(127)),
                    int'($urandom_range(8191)), md, int'($urandom_range(1)), i % 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
